video_mem_arbiter: RTL and testbench
====================================

Name: video_mem_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between the pixel fetch path and the CPU native memory bus.
- Video fetch has absolute priority and a fixed 1-cycle read latency, so character and font fetches never slip.
- CPU accesses are issued only in cycles with no video request. The CPU is held off with ready until its access completes.
- Saturating stall statistics are kept for firmware and debug.

Parameters:
- MEM_BASE, 32'h01000000, byte base address of the RAM window in CPU space.
- ADDR_W, 10, RAM word-address width (RAM depth = 2**ADDR_W words).

Ports:
- clk  in  1  single clock for the block and the RAM.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video read request this cycle.
- vid_addr  in  32  video byte address; bits [ADDR_W+1:2] are used.
- vid_rdata  out  32  video read data.
- vid_rdata_valid  out  1  vid_rdata is valid (request cycle + 1).
- cpu_valid  in  1  CPU access request; held until cpu_ready.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  byte write enables; 0 means read.
- cpu_ready  out  1  one-cycle access-complete pulse.
- cpu_rdata  out  32  CPU read data, valid while cpu_ready=1.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wren  out  4  RAM byte write enables.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data for the address presented in the previous cycle.
- stall_count  out  16  saturating count of cycles a CPU access waited on video.
- max_stall  out  8  longest single CPU wait observed, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: state=IDLE, cpu_ready=0, vid_rdata_valid=0, stall_count=0, max_stall=0, mem_wren=0.
  - Reset mid-access: any in-flight CPU access is dropped without a ready pulse. No RAM write occurs in the reset cycle.
- Port mux, combinational:
  - vid_req=1: mem_addr=vid_addr[ADDR_W+1:2], mem_wren=0.
  - Else, in IDLE with an in-range cpu_valid: mem_addr=cpu_addr[ADDR_W+1:2], mem_wren=cpu_wstrb, mem_wdata=cpu_wdata.
  - Otherwise: mem_wren=0 and mem_addr=vid_addr bits.
- Video path:
  - vid_rdata_valid <= vid_req (registered).
  - vid_rdata = mem_rdata (combinational).
  - Latency is exactly 1 cycle. Back-to-back video requests are allowed every cycle.
- In-range test: cpu_addr - MEM_BASE < 4*2**ADDR_W, using unsigned 32-bit subtraction.
- CPU FSM, states IDLE, RESP:
  - IDLE, cpu_valid=1, in range, vid_req=0: issue the access to the RAM this cycle -> RESP.
  - IDLE, cpu_valid=1, in range, vid_req=1: stay in IDLE; stall_count += 1 (saturate at 16'hFFFF); cur_wait += 1 (8-bit, saturating).
  - IDLE, cpu_valid=1, out of range: no RAM access; -> RESP with rdata forced to 0 and writes discarded.
  - RESP: cpu_ready=1 for exactly one cycle; cpu_rdata=mem_rdata (0 if the access was out of range); -> IDLE unconditionally. Also update max_stall <= max(max_stall, cur_wait) and clear cur_wait.
  - In the cycle after RESP, cpu_valid is deasserted by the CPU. The FSM re-samples it only in IDLE, so a new access costs at least 2 cycles.
- Write completion: a write commits in the issue cycle; cpu_ready follows in the next cycle.
- Priority of simultaneous events:
  - vid_req coinciding with CPU issue: video always wins; the CPU retries the next cycle.
  - vid_req during RESP: granted normally. It does not corrupt cpu_rdata, because mem_rdata in RESP reflects the CPU issue cycle.
- CPU starvation is bounded only by video traffic. The video fetch pattern of at most 1 request per 8 pixels keeps waits short; max_stall exposes the worst case.

Test Plan:
- Reset with cpu_valid=1 and vid_req=1 -> cpu_ready=0, vid_rdata_valid=0, stall_count=0, mem_wren=0. First CPU access after reset completes in 2 cycles.
- RAM word 5 = 32'hDEADBEEF; vid_req=1 with vid_addr=MEM_BASE+20 -> mem_addr=5 in the same cycle; next cycle vid_rdata_valid=1 and vid_rdata=32'hDEADBEEF.
- CPU write cpu_addr=MEM_BASE+8, cpu_wstrb=4'b0011, cpu_wdata=32'h12345678 over old word 32'hAAAAAAAA -> cpu_ready pulses at cycle 1. A read-back of the same address returns 32'hAAAA5678.
- cpu_valid held while vid_req=1 for 3 consecutive cycles -> no CPU issue during those cycles; issue in cycle 3, cpu_ready in cycle 4; stall_count=3, max_stall=3.
- Out-of-range read at cpu_addr=MEM_BASE+4*2**ADDR_W -> cpu_ready after 1 cycle, cpu_rdata=0, mem_wren stays 0. The same address as a write leaves the RAM unchanged.
- Assert reset in the RESP cycle of a read -> no cpu_ready pulse, FSM in IDLE the next cycle, counters 0.

Source files
------------

// File: rtl/video_mem_arbiter_if.sv
// CPU native memory bus between a CPU-side master and the video RAM arbiter.
// The master holds valid with a stable address/data until ready pulses.
interface video_mem_arbiter_if;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/video_mem_arbiter.sv
// Shares one single-port synchronous-read video RAM between the pixel fetch
// path (absolute priority, fixed 1-cycle latency) and the CPU memory bus.
module video_mem_arbiter #(
   parameter logic [31:0] MEM_BASE = 32'h01000000,
   parameter int          ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [31:0]       vid_addr,
   output logic [31:0]       vid_rdata,
   output logic              vid_rdata_valid,
   video_mem_arbiter_if.slave cpu,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wren,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [15:0]       stall_count,
   output logic [7:0]        max_stall
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   localparam logic [31:0] WINDOW_BYTES = 32'd4 << ADDR_W;

   state_t            state;
   state_t            state_next;
   logic [31:0]       cpu_offset;
   logic              in_range;
   logic              cpu_req;
   logic              cpu_issue;
   logic              cpu_stall;
   logic              resp_oor;
   logic [7:0]        cur_wait;
   logic [ADDR_W-1:0] vid_word;
   logic [ADDR_W-1:0] cpu_word;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{vid_addr[31:ADDR_W+2], vid_addr[1:0]};

   // Unsigned wrap makes addresses below MEM_BASE fall out of range too.
   assign cpu_offset = cpu.addr - MEM_BASE;
   assign in_range   = cpu_offset < WINDOW_BYTES;
   assign vid_word   = vid_addr[ADDR_W+1:2];
   assign cpu_word   = cpu.addr[ADDR_W+1:2];

   assign cpu_req   = (state == IDLE) && cpu.valid;
   assign cpu_issue = cpu_req && in_range && !vid_req && !reset;
   assign cpu_stall = cpu_req && in_range && vid_req;

   assign vid_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cpu_req && (!in_range || !vid_req)) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // mem_rdata during RESP still belongs to the CPU issue cycle, so a video
   // grant in RESP cannot disturb the CPU read data.
   always_comb begin
      mem_addr  = vid_word;
      mem_wren  = 4'b0000;
      mem_wdata = cpu.wdata;
      cpu.ready = 1'b0;
      cpu.rdata = 32'h0;
      if (cpu_issue) begin
         mem_addr = cpu_word;
         mem_wren = cpu.wstrb;
      end
      if ((state == RESP) && !reset) begin
         cpu.ready = 1'b1;
         cpu.rdata = resp_oor ? 32'h0 : mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vid_rdata_valid <= 1'b0;
         resp_oor        <= 1'b0;
         cur_wait        <= 8'h00;
         stall_count     <= 16'h0000;
         max_stall       <= 8'h00;
      end else begin
         vid_rdata_valid <= vid_req;
         if (state == IDLE) begin
            resp_oor <= !in_range;
         end
         if (cpu_stall) begin
            if (stall_count != 16'hFFFF) begin
               stall_count <= stall_count + 16'd1;
            end
            if (cur_wait != 8'hFF) begin
               cur_wait <= cur_wait + 8'd1;
            end
         end
         if (state == RESP) begin
            if (cur_wait > max_stall) begin
               max_stall <= cur_wait;
            end
            cur_wait <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Scoreboard bench for video_mem_arbiter: a behavioural RAM sits on the mem
// port, and a shadow copy of it predicts every video and CPU read result.
module tb_video_mem_arbiter;

   localparam logic [31:0] MEM_BASE = 32'h01000000;
   localparam int          ADDR_W   = 10;
   localparam int          DEPTH    = 1 << ADDR_W;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } cpu_exp_t;

   logic              clk;
   logic              reset;
   logic              vid_req;
   logic [31:0]       vid_addr;
   logic [31:0]       vid_rdata;
   logic              vid_rdata_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wren;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic [15:0]       stall_count;
   logic [7:0]        max_stall;

   video_mem_arbiter_if cpu_bus ();

   video_mem_arbiter #(
      .MEM_BASE(MEM_BASE),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vid_req        (vid_req),
      .vid_addr       (vid_addr),
      .vid_rdata      (vid_rdata),
      .vid_rdata_valid(vid_rdata_valid),
      .cpu            (cpu_bus),
      .mem_addr       (mem_addr),
      .mem_wren       (mem_wren),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .stall_count    (stall_count),
      .max_stall      (max_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] ram    [0:DEPTH-1];
   logic [31:0] shadow [0:DEPTH-1];

   // Single-port RAM with read-old-data behaviour and byte enables.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_wren[b]) begin
            ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      mem_rdata <= ram[mem_addr];
   end

   logic [31:0] vid_q [$];
   cpu_exp_t    cpu_q [$];
   logic [31:0] vid_e;
   cpu_exp_t    cpu_e;
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Pops a prediction whenever the DUT presents video or CPU read data.
   always @(negedge clk) begin
      if (!reset) begin
         if (vid_rdata_valid) begin
            if (vid_q.size() == 0) begin
               checkOutput("vid_spurious_valid", 32'(vid_rdata_valid), 32'd0);
            end else begin
               vid_e = vid_q.pop_front();
               checkOutput("vid_rdata", vid_rdata, vid_e);
            end
         end
         if (cpu_bus.ready) begin
            if (cpu_q.size() == 0) begin
               checkOutput("cpu_spurious_ready", 32'(cpu_bus.ready), 32'd0);
            end else begin
               cpu_e = cpu_q.pop_front();
               if (cpu_e.is_read) begin
                  checkOutput("cpu_rdata", cpu_bus.rdata, cpu_e.data);
               end
            end
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a);
      vid_req  = v;
      vid_addr = a;
      if (v) begin
         vid_q.push_back(shadow[a[ADDR_W+1:2]]);
      end
   endtask

   function automatic logic inWindow(input logic [31:0] a);
      logic [31:0] off;
      off = a - MEM_BASE;
      return off < 32'(DEPTH * 4);
   endfunction

   function automatic cpu_exp_t predictCpu(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      cpu_exp_t    e;
      int          idx;
      logic [31:0] w;
      idx       = int'(a[ADDR_W+1:2]);
      e.is_read = (ws == 4'b0000);
      e.data    = 32'h0;
      if (inWindow(a)) begin
         if (e.is_read) begin
            e.data = shadow[idx];
         end else begin
            w = shadow[idx];
            for (int b = 0; b < 4; b++) begin
               if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
            shadow[idx] = w;
         end
      end
      return e;
   endfunction

   // Runs one CPU access with vid_req low; returns cycles until ready.
   task automatic cpuAccess(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output int lat, output logic [31:0] rd);
      logic inr;
      inr = inWindow(a);
      cpu_q.push_back(predictCpu(a, wd, ws));
      cpu_bus.valid = 1'b1;
      cpu_bus.addr  = a;
      cpu_bus.wdata = wd;
      cpu_bus.wstrb = ws;
      lat = 0;
      @(negedge clk);
      checkOutput("issue_wren", 32'(mem_wren), inr ? 32'(ws) : 32'd0);
      if (inr) begin
         checkOutput("issue_addr", 32'(mem_addr), 32'(a[ADDR_W+1:2]));
      end
      while (!cpu_bus.ready && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!cpu_bus.ready) begin
         checkOutput("cpu_ready_timeout", 32'(cpu_bus.ready), 32'd1);
      end
      rd = cpu_bus.rdata;
      stepCycle();
      cpu_bus.valid = 1'b0;
      cpu_bus.wstrb = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [31:0] seed_data;
      int          idx;

      reset         = 1'b1;
      vid_req       = 1'b1;
      vid_addr      = MEM_BASE;
      cpu_bus.valid = 1'b1;
      cpu_bus.addr  = MEM_BASE;
      cpu_bus.wdata = 32'h55555555;
      cpu_bus.wstrb = 4'b1111;

      // Reset with both requesters active.
      stepCycle();
      @(negedge clk);
      checkOutput("rst_cpu_ready", 32'(cpu_bus.ready), 32'd0);
      checkOutput("rst_vid_valid", 32'(vid_rdata_valid), 32'd0);
      checkOutput("rst_stall_count", 32'(stall_count), 32'd0);
      checkOutput("rst_max_stall", 32'(max_stall), 32'd0);
      checkOutput("rst_wren", 32'(mem_wren), 32'd0);
      stepCycle();
      vid_req = 1'b0;
      @(negedge clk);
      checkOutput("rst_wren_no_vid", 32'(mem_wren), 32'd0);
      checkOutput("rst_ready_no_vid", 32'(cpu_bus.ready), 32'd0);
      stepCycle();
      reset         = 1'b0;
      cpu_bus.valid = 1'b0;
      cpu_bus.wstrb = 4'b0000;

      // Fill words 0..15; word 5 and word 2 carry the documented patterns.
      for (int i = 0; i < 16; i++) begin
         seed_data = 32'hC0DE0000 | 32'(i);
         if (i == 5) seed_data = 32'hDEADBEEF;
         if (i == 2) seed_data = 32'hAAAAAAAA;
         cpuAccess(MEM_BASE + 32'(4 * i), seed_data, 4'b1111, lat, rd);
         if (i == 0) checkOutput("first_access_latency", 32'(lat), 32'd1);
      end

      // Single video fetch of word 5.
      applyStimulus(1'b1, MEM_BASE + 32'd20);
      @(negedge clk);
      checkOutput("vid_mem_addr", 32'(mem_addr), 32'd5);
      checkOutput("vid_wren", 32'(mem_wren), 32'd0);
      stepCycle();
      applyStimulus(1'b0, MEM_BASE);
      @(negedge clk);
      checkOutput("vid_valid_latency", 32'(vid_rdata_valid), 32'd1);
      checkOutput("vid_deadbeef", vid_rdata, 32'hDEADBEEF);
      stepCycle();

      // Back-to-back video fetches every cycle.
      for (int k = 0; k < 8; k++) begin
         idx = $urandom_range(0, 15);
         applyStimulus(1'b1, MEM_BASE + 32'(4 * idx));
         @(negedge clk);
         checkOutput("vid_b2b_addr", 32'(mem_addr), 32'(idx));
         stepCycle();
      end
      applyStimulus(1'b0, MEM_BASE);
      stepCycle();
      stepCycle();

      // Partial write then read-back.
      cpuAccess(MEM_BASE + 32'd8, 32'h12345678, 4'b0011, lat, rd);
      checkOutput("write_latency", 32'(lat), 32'd1);
      cpuAccess(MEM_BASE + 32'd8, 32'h0, 4'b0000, lat, rd);
      checkOutput("write_readback", rd, 32'hAAAA5678);

      // CPU read held off by three video cycles, video also granted in RESP.
      cpu_q.push_back(predictCpu(MEM_BASE + 32'd20, 32'h0, 4'b0000));
      cpu_bus.valid = 1'b1;
      cpu_bus.addr  = MEM_BASE + 32'd20;
      cpu_bus.wstrb = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, MEM_BASE + 32'(4 * (i + 8)));
         @(negedge clk);
         checkOutput("stall_no_ready", 32'(cpu_bus.ready), 32'd0);
         checkOutput("stall_vid_addr", 32'(mem_addr), 32'(i + 8));
         stepCycle();
      end
      applyStimulus(1'b0, MEM_BASE);
      @(negedge clk);
      checkOutput("stall_issue_addr", 32'(mem_addr), 32'd5);
      checkOutput("stall_issue_no_ready", 32'(cpu_bus.ready), 32'd0);
      stepCycle();
      applyStimulus(1'b1, MEM_BASE + 32'd8);
      @(negedge clk);
      checkOutput("stall_ready", 32'(cpu_bus.ready), 32'd1);
      checkOutput("resp_vid_addr", 32'(mem_addr), 32'd2);
      checkOutput("resp_rdata", cpu_bus.rdata, 32'hDEADBEEF);
      stepCycle();
      cpu_bus.valid = 1'b0;
      applyStimulus(1'b0, MEM_BASE);
      @(negedge clk);
      checkOutput("stall_count", 32'(stall_count), 32'd3);
      checkOutput("max_stall", 32'(max_stall), 32'd3);
      stepCycle();

      // Out-of-range accesses, at the window top and just below the base.
      cpuAccess(MEM_BASE + 32'(4 * DEPTH), 32'h0, 4'b0000, lat, rd);
      checkOutput("oor_latency", 32'(lat), 32'd1);
      checkOutput("oor_rdata", rd, 32'h0);
      cpuAccess(MEM_BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'b1111, lat, rd);
      cpuAccess(MEM_BASE, 32'h0, 4'b0000, lat, rd);
      checkOutput("oor_write_discarded", rd, 32'hC0DE0000);
      cpuAccess(MEM_BASE - 32'd4, 32'h0, 4'b0000, lat, rd);
      checkOutput("below_base_rdata", rd, 32'h0);

      // Mixed random byte writes and reads.
      for (int k = 0; k < 12; k++) begin
         idx = $urandom_range(0, 15);
         cpuAccess(MEM_BASE + 32'(4 * idx), $urandom, 4'($urandom_range(1, 15)), lat, rd);
         cpuAccess(MEM_BASE + 32'(4 * idx), 32'h0, 4'b0000, lat, rd);
      end

      // Reset landing in the RESP cycle of a read drops the access.
      cpu_bus.valid = 1'b1;
      cpu_bus.addr  = MEM_BASE + 32'd20;
      cpu_bus.wstrb = 4'b0000;
      @(negedge clk);
      stepCycle();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_resp_no_ready", 32'(cpu_bus.ready), 32'd0);
      stepCycle();
      reset         = 1'b0;
      cpu_bus.valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_resp_ready_after", 32'(cpu_bus.ready), 32'd0);
      checkOutput("rst_resp_stall_count", 32'(stall_count), 32'd0);
      checkOutput("rst_resp_max_stall", 32'(max_stall), 32'd0);
      stepCycle();
      cpuAccess(MEM_BASE + 32'd20, 32'h0, 4'b0000, lat, rd);
      checkOutput("post_reset_latency", 32'(lat), 32'd1);

      stepCycle();
      stepCycle();
      checkOutput("vid_queue_drained", 32'(vid_q.size()), 32'd0);
      checkOutput("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
